// File: rtl/serial_bus_if.sv
// serial_bus_if: bit-serial master/slave bus between one master and a slave.
//   valid       master frame/beat valid
//   write_en    1 = write, 0 = read (sampled on the first header bit)
//   addr_rx     serial 14-bit address, MSB first
//   data_rx_m   serial write data, MSB first
//   burst_mode  serial 3-bit burst code, MSB first
//   slave_ready one-cycle pulse: slave ready for the next burst-write beat
//   slave_valid one-cycle pulse: read data follows on data_tx_s
//   data_tx_s   serial read data, MSB first
//   slave_busy  slave is servicing a transaction
interface serial_bus_if;
    logic valid;
    logic write_en;
    logic addr_rx;
    logic data_rx_m;
    logic burst_mode;
    logic slave_ready;
    logic slave_valid;
    logic data_tx_s;
    logic slave_busy;

    modport master (
        output valid, write_en, addr_rx, data_rx_m, burst_mode,
        input  slave_ready, slave_valid, data_tx_s, slave_busy
    );

    modport slave (
        input  valid, write_en, addr_rx, data_rx_m, burst_mode,
        output slave_ready, slave_valid, data_tx_s, slave_busy
    );
endinterface

// File: rtl/serial_bus_slave.sv
// serial_bus_slave: responder end of the serial bus. Deserialises a 14-bit
// address / 8-bit data / 3-bit burst-code header, services single and burst
// reads and writes against a local byte memory, and returns read data
// serially, MSB first.
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      serial_bus_if.slave (see serial_bus_if for signal meanings)
module serial_bus_slave #(
    parameter logic [1:0]  SLAVE_ID  = 2'd0,
    parameter int unsigned MEM_DEPTH = 4096,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned READY_LAT = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    serial_bus_if.slave  bus
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [3:0] {
        IDLE, HDR, DROP, WR_STORE, WR_READY, WR_BEAT, RD_WAIT, RD_VALID, RD_SEND
    } state_e;

    state_e        state_q;
    logic [12:0]   addr_q;      // header address shift register (top 13 bits so far)
    logic [7:0]    data_q;      // write data shift register
    logic [2:0]    code_q;      // burst code shift register
    logic [7:0]    sh_q;        // read data being shifted out
    logic [7:0]    rd_q;        // synchronous memory read output
    logic [3:0]    bit_cnt_q;
    logic [3:0]    lat_cnt_q;
    logic [9:0]    beat_q;      // index of the current beat, header beat = 0
    logic [AW-1:0] baddr_q;     // current beat address, wraps inside the memory
    logic          wen_q;
    logic          ready_q, valid_q, tx_q, busy_q;

    logic [13:0]   hdr_addr;
    logic          last_beat;
    logic          mem_we, mem_re;

    logic [7:0]    mem [MEM_DEPTH];

    function automatic logic [9:0] last_idx(input logic [2:0] c);
        case (c)
            3'd1:    return 10'd7;
            3'd2:    return 10'd15;
            3'd3:    return 10'd31;
            3'd4:    return 10'd63;
            3'd5:    return 10'd127;
            3'd6:    return 10'd255;
            3'd7:    return 10'd511;
            default: return 10'd0;
        endcase
    endfunction

    // Address as it will stand once the current header bit is shifted in.
    assign hdr_addr  = {addr_q, bus.addr_rx};
    assign last_beat = (beat_q == last_idx(code_q));

    // Store happens only on the first WR_STORE cycle; the remaining cycles
    // there are the ready-latency wait. Likewise the read is issued once.
    assign mem_we = (state_q == WR_STORE) && (lat_cnt_q == 4'd0);
    assign mem_re = (state_q == RD_WAIT)  && (lat_cnt_q == 4'd0);

    // Memory is not reset: contents survive a reset.
    always_ff @(posedge clock) begin
        if (mem_we) mem[baddr_q] <= data_q;
        if (mem_re) rd_q <= mem[baddr_q];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            code_q    <= '0;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            lat_cnt_q <= '0;
            beat_q    <= '0;
            baddr_q   <= '0;
            wen_q     <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.valid) begin
                        wen_q     <= bus.write_en;
                        addr_q    <= {12'd0, bus.addr_rx};
                        bit_cnt_q <= 4'd1;
                        busy_q    <= 1'b1;
                        state_q   <= HDR;
                    end
                end
                HDR: begin
                    if (!bus.valid) begin
                        // Aborted frame: nothing is stored.
                        bit_cnt_q <= 4'd0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        addr_q <= hdr_addr[12:0];
                        if (bit_cnt_q >= 4'd6)  data_q <= {data_q[6:0], bus.data_rx_m};
                        if (bit_cnt_q >= 4'd11) code_q <= {code_q[1:0], bus.burst_mode};
                        if (bit_cnt_q == 4'd13) begin
                            bit_cnt_q <= 4'd0;
                            lat_cnt_q <= 4'd0;
                            beat_q    <= 10'd0;
                            baddr_q   <= hdr_addr[AW-1:0];
                            if (hdr_addr[13:12] != SLAVE_ID) begin
                                busy_q  <= 1'b0;
                                state_q <= DROP;
                            end else if (wen_q) begin
                                state_q <= WR_STORE;
                            end else begin
                                state_q <= RD_WAIT;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                DROP: begin
                    if (!bus.valid) state_q <= IDLE;
                end
                WR_STORE: begin
                    if (lat_cnt_q == 4'd0 && last_beat) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        if (lat_cnt_q == 4'd0) begin
                            baddr_q <= baddr_q + AW'(1);
                            beat_q  <= beat_q + 10'd1;
                        end
                        if (lat_cnt_q == 4'(READY_LAT - 1)) begin
                            lat_cnt_q <= 4'd0;
                            ready_q   <= 1'b1;
                            state_q   <= WR_READY;
                        end else begin
                            lat_cnt_q <= lat_cnt_q + 4'd1;
                        end
                    end
                end
                WR_READY: begin
                    bit_cnt_q <= 4'd0;
                    state_q   <= WR_BEAT;
                end
                WR_BEAT: begin
                    // Idle edges (valid=0) hold the bit counter.
                    if (bus.valid) begin
                        data_q <= {data_q[6:0], bus.data_rx_m};
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= 4'd0;
                            lat_cnt_q <= 4'd0;
                            state_q   <= WR_STORE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt_q == 4'(READ_LAT - 1)) begin
                        lat_cnt_q <= 4'd0;
                        valid_q   <= 1'b1;
                        state_q   <= RD_VALID;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 4'd1;
                    end
                end
                RD_VALID: begin
                    sh_q      <= rd_q;
                    tx_q      <= rd_q[7];
                    bit_cnt_q <= 4'd0;
                    state_q   <= RD_SEND;
                end
                RD_SEND: begin
                    if (bit_cnt_q == 4'd7) begin
                        tx_q      <= 1'b0;
                        bit_cnt_q <= 4'd0;
                        if (last_beat) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            baddr_q   <= baddr_q + AW'(1);
                            beat_q    <= beat_q + 10'd1;
                            lat_cnt_q <= 4'd0;
                            state_q   <= RD_WAIT;
                        end
                    end else begin
                        sh_q      <= {sh_q[6:0], 1'b0};
                        tx_q      <= sh_q[6];
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.slave_ready = ready_q;
    assign bus.slave_valid = valid_q;
    assign bus.data_tx_s   = tx_q;
    assign bus.slave_busy  = busy_q;
endmodule

// File: tb/tb_serial_bus_slave.sv
// tb_serial_bus_slave: directed stimulus with a read-data scoreboard. The
// stimulus pushes expected read bytes; a monitor pops and compares each byte
// it deserialises after a slave_valid pulse.
module tb_serial_bus_slave;
    localparam int READ_LAT  = 2;
    localparam int READY_LAT = 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    serial_bus_if bus ();

    serial_bus_slave #(
        .SLAVE_ID (2'd0),
        .MEM_DEPTH(4096),
        .READ_LAT (READ_LAT),
        .READY_LAT(READY_LAT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [7:0] d;
        int         lat;   // expected header-to-valid cycles, 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   nv = 0;
    int   nr = 0;
    time  t_hdr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts pulses and checks every returned byte.
    initial begin
        logic [7:0] got;
        bit         ok;
        exp_t       e;
        forever begin
            @(negedge clock);
            if (reset_n && bus.slave_ready) nr++;
            if (reset_n && bus.slave_valid) begin
                nv++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_slave_valid", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q[0];
                    if (e.lat > 0)
                        chk("read_latency", 32'((($time - t_hdr) + 5) / 10), 32'(e.lat));
                    ok  = 1'b1;
                    got = 8'd0;
                    for (int i = 0; i < 8; i++) begin
                        @(negedge clock);
                        if (!reset_n) begin ok = 1'b0; break; end
                        got = {got[6:0], bus.data_tx_s};
                    end
                    void'(exp_q.pop_front());
                    if (ok) chk("read_byte", 32'(got), 32'(e.d));
                end
            end
        end
    end

    task automatic send_hdr(input logic we, input logic [13:0] a, input logic [7:0] d,
                            input logic [2:0] c, input int abort_at);
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            if (k == abort_at) begin
                bus.valid = 1'b0;
                return;
            end
            bus.valid      = 1'b1;
            bus.write_en   = we;
            bus.addr_rx    = a[13-k];
            bus.data_rx_m  = 1'b0;
            bus.burst_mode = 1'b0;
            if (k >= 6)  bus.data_rx_m  = d[13-k];
            if (k >= 11) bus.burst_mode = c[13-k];
        end
        @(posedge clock);
        t_hdr = $time;
        #1;
        bus.valid      = 1'b0;
        bus.data_rx_m  = 1'b0;
        bus.burst_mode = 1'b0;
    endtask

    // One burst-write beat; gap >= 0 inserts an idle (valid=0) edge before that bit.
    task automatic send_beat(input logic [7:0] d, input int gap);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.slave_ready) begin seen = 1'b1; break; end
        end
        chk("ready_seen", 32'(seen), 32'd1);
        if (!seen) return;
        for (int i = 0; i < 8; i++) begin
            if (i == gap) begin
                @(negedge clock);
                bus.valid     = 1'b0;
                bus.data_rx_m = ~d[7-i];
            end
            @(negedge clock);
            bus.valid     = 1'b1;
            bus.data_rx_m = d[7-i];
        end
        @(posedge clock);
        #1;
        bus.valid     = 1'b0;
        bus.data_rx_m = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !bus.slave_busy) begin done = 1'b1; break; end
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic read1(input logic [13:0] a, input logic [7:0] d, input string name);
        exp_q.push_back('{d, READ_LAT + 1});
        send_hdr(1'b0, a, 8'h00, 3'd0, 14);
        wait_idle(name);
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_ready"}, 32'(bus.slave_ready), 32'd0);
        chk({name, "_valid"}, 32'(bus.slave_valid), 32'd0);
        chk({name, "_tx"},    32'(bus.data_tx_s),   32'd0);
        chk({name, "_busy"},  32'(bus.slave_busy),  32'd0);
    endtask

    initial begin
        int  v0, r0;
        bit  got3;
        bus.valid      = 1'b0;
        bus.write_en   = 1'b0;
        bus.addr_rx    = 1'b0;
        bus.data_rx_m  = 1'b0;
        bus.burst_mode = 1'b0;
        repeat (3) @(negedge clock);
        chk_quiet("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Single write then read back.
        send_hdr(1'b1, 14'h0123, 8'hA5, 3'd0, 14);
        chk("busy_after_hdr", 32'(bus.slave_busy), 32'd1);
        wait_idle("wr_single_done");
        read1(14'h0123, 8'hA5, "rd_single_done");

        // Foreign slave id: dropped, memory untouched.
        v0 = nv; r0 = nr;
        send_hdr(1'b1, 14'h1123, 8'h5A, 3'd0, 14);
        chk("drop_busy", 32'(bus.slave_busy), 32'd0);
        repeat (20) @(negedge clock);
        chk("drop_no_valid", 32'(nv - v0), 32'd0);
        chk("drop_no_ready", 32'(nr - r0), 32'd0);
        read1(14'h0123, 8'hA5, "rd_after_drop");

        // Burst write of 8 beats wrapping past the top of memory.
        r0 = nr;
        send_hdr(1'b1, 14'h0FFE, 8'h10, 3'd1, 14);
        for (int i = 1; i < 8; i++) send_beat(8'(8'h10 + i), (i == 4) ? 3 : -1);
        wait_idle("burst_wr_done");
        chk("burst_wr_ready_cnt", 32'(nr - r0), 32'd7);

        // Burst read of the same span.
        v0 = nv;
        for (int i = 0; i < 8; i++) exp_q.push_back('{8'(8'h10 + i), (i == 0) ? READ_LAT + 1 : 0});
        send_hdr(1'b0, 14'h0FFE, 8'h00, 3'd1, 14);
        wait_idle("burst_rd_done");
        chk("burst_rd_valid_cnt", 32'(nv - v0), 32'd8);
        chk("burst_rd_busy_end", 32'(bus.slave_busy), 32'd0);
        read1(14'h0000, 8'h12, "rd_wrapped");

        // Aborted header leaves memory alone; a full write afterwards works.
        send_hdr(1'b1, 14'h0200, 8'h3C, 3'd0, 14);
        wait_idle("wr_pre_abort");
        send_hdr(1'b1, 14'h0200, 8'h77, 3'd0, 9);
        repeat (3) @(negedge clock);
        chk("abort_busy", 32'(bus.slave_busy), 32'd0);
        read1(14'h0200, 8'h3C, "rd_after_abort");
        send_hdr(1'b1, 14'h0200, 8'h77, 3'd0, 14);
        wait_idle("wr_after_abort");
        read1(14'h0200, 8'h77, "rd_new_write");

        // Reset in the middle of beat 3 of a burst read.
        v0 = nv;
        for (int i = 0; i < 3; i++) exp_q.push_back('{8'(8'h10 + i), (i == 0) ? READ_LAT + 1 : 0});
        send_hdr(1'b0, 14'h0FFE, 8'h00, 3'd1, 14);
        got3 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (nv - v0 >= 3) begin got3 = 1'b1; break; end
        end
        chk("beat3_reached", 32'(got3), 32'd1);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 chk_quiet("mid_reset");
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        chk("queue_after_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (30) @(negedge clock);
        chk("no_valid_after_reset", 32'(nv - v0), 32'd3);
        read1(14'h0005, 8'h17, "rd_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_bus_slave.md
Name: serial_bus_slave

Overview:
- Responder end of the serial master/slave bus: deserialises the 14-bit address, 8-bit data and 3-bit burst code from a master and services single and burst reads and writes.
- Holds a local byte memory and returns read data serially, MSB first.
- Sits on the bus behind the arbiter, one instance per slave, selected by the top address bits.

Parameters:
- SLAVE_ID, 2'd0, slave select; frame accepted only when addr[13:12] == SLAVE_ID.
- MEM_DEPTH, 4096, byte entries; the low 12 address bits index it; power of two.
- READ_LAT, 2, idle cycles from header end to the first slave_valid pulse; range 1..15.
- READY_LAT, 1, cycles from storing a burst-write beat to the slave_ready pulse; range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- valid  in  1  master frame/beat valid.
- write_en  in  1  1 = write, 0 = read; sampled on the first header bit.
- addr_rx  in  1  serial address, MSB first.
- data_rx_m  in  1  serial write data, MSB first.
- burst_mode  in  1  serial burst code, MSB first.
- slave_ready  out  1  one-cycle pulse: ready for the next burst-write beat.
- slave_valid  out  1  one-cycle pulse: read data follows.
- data_tx_s  out  1  serial read data, MSB first.
- slave_busy  out  1  high from the first header bit until the transaction ends.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, FSM to IDLE, all counters 0. Memory contents are not cleared.
- Header: on the first edge with valid=1 in IDLE, latch write_en and sample addr_rx bit 13. On each following edge while valid=1, take the next address bit; 14 edges total (bit_cnt 0..13).
  - data_rx_m is sampled at bit_cnt 6..13 as data[7:0].
  - burst_mode is sampled at bit_cnt 11..13 as code[2:0].
- valid drops before bit_cnt 13: frame aborted, return to IDLE, no memory write.
- Address mismatch: after the header, go to DROP; stay there until valid=0, then IDLE. No outputs asserted.
- Burst length: code 0 = single; codes 1..7 = 8,16,32,64,128,256,512 beats. The header beat counts as beat 1.
- Beat address: header address + beat index, wrapping modulo MEM_DEPTH. It does not carry into the SLAVE_ID bits.
- FSM states: IDLE, HDR, DROP, WR_STORE, WR_READY, WR_BEAT, RD_WAIT, RD_VALID, RD_SEND.
  - HDR -> WR_STORE for a write, RD_WAIT for a read.
  - WR_STORE: write mem[addr] = data.
    - Single write, or beat count reached: go to IDLE.
    - Otherwise wait READY_LAT cycles, then WR_READY.
  - WR_READY: slave_ready=1 for exactly one cycle, then WR_BEAT.
  - WR_BEAT: take 8 data bits, one per edge with valid=1, MSB first, then WR_STORE.
    - Edges with valid=0 are ignored (the bit counter holds).
  - RD_WAIT: READ_LAT cycles; the synchronous memory read is issued on its first cycle. Then RD_VALID.
  - RD_VALID: slave_valid=1 for one cycle. The data register is loaded with the memory byte.
  - RD_SEND: data_tx_s presents bit 7 in the first cycle, down to bit 0 in the 8th; then data_tx_s=0.
    - Beats remaining: go to RD_WAIT with the incremented address.
    - Otherwise go to IDLE.
- A read returns memory contents; a write followed immediately by a read of the same address returns the new byte.
- slave_busy=1 in every state except IDLE and DROP.
- valid=1 on the cycle the FSM returns to IDLE starts a new header on the next edge. It is not sampled in the same cycle.
- In IDLE, RD_* and WR_READY, data_rx_m and burst_mode are ignored.
- A reset mid-burst discards remaining beats. Bytes already stored remain.

Test Plan:
- Single write, addr 14'h0123 (SLAVE_ID 0), data 8'hA5; then single read of 14'h0123 -> after READ_LAT+1 cycles a slave_valid pulse, then data_tx_s = 1,0,1,0,0,1,0,1.
- Header address 14'h1123 with SLAVE_ID 0 -> DROP, no slave_valid/slave_ready, and mem[0x123] is unchanged on a later read.
- Burst write code 1, start addr 14'h0FFE, data 8'h10..8'h17 -> 7 slave_ready pulses; mem[0xFFE]=8'h10, mem[0xFFF]=8'h11, mem[0x000]..mem[0x005]=8'h12..8'h17 (wrap).
- Burst read code 1 from 14'h0FFE after the previous test -> 8 slave_valid pulses, bytes 8'h10..8'h17 in order, each 8 bits MSB first, then IDLE with slave_busy=0.
- Header aborted: valid drops at bit_cnt 9 -> IDLE, no write; the following full write to the same address completes normally.
- reset_n pulsed low during beat 3 of a burst read -> all outputs 0 immediately; a new single read afterwards behaves normally.
